// File: rtl/encoder_fec_pkg.sv
// Shared FEC encoder types, plus the state encoding of the encoder arbiter.
package encoder_fec_pkg;

  typedef logic [7:0]  message_data_t;
  typedef logic [15:0] encoded_message_data_t;

  localparam int HALF_CLK_PERIOD = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fec_rr_pick.sv
// Rotating-priority pick: first set request strictly after last_grant, wrapping.
module fec_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] last_grant,
  output logic [SRC_W-1:0] grant,
  output logic             grant_valid
);

  // cand[gi] is the channel sitting gi+1 places after last_grant
  logic [SRC_W-1:0] cand [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [SRC_W:0] sum;
      assign sum = {1'b0, last_grant} + (SRC_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (SRC_W+1)'(N_REQ)) ? SRC_W'(sum - (SRC_W+1)'(N_REQ))
                                                   : sum[SRC_W-1:0];
    end
  endgenerate

  // Walk from farthest to nearest so the nearest requesting channel wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        grant       = cand[i];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fec_encoder_arbiter.sv
// Round-robin sharing of one FEC encoder among N_REQ requesters, with a
// per-transaction watchdog that aborts a hung encoder handshake.
module fec_encoder_arbiter
  import encoder_fec_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int TIMEOUT_CYC = 64,
  localparam int SRC_W       = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_REQ-1:0]      req_in,
  input  message_data_t         data_in [N_REQ],
  output logic [N_REQ-1:0]      ack_out,
  output encoded_message_data_t data_out,
  output logic [SRC_W-1:0]      src_id,
  output logic                  enc_req,
  output message_data_t         enc_data,
  input  logic                  enc_ack,
  input  encoded_message_data_t enc_result,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  arb_state_t            state_reg, state_next;
  logic [SRC_W-1:0]      grant_reg, grant_next;
  logic [SRC_W-1:0]      last_grant_reg, last_grant_next;
  message_data_t         enc_data_reg, enc_data_next;
  encoded_message_data_t data_out_reg, data_out_next;
  logic [SRC_W-1:0]      src_id_reg, src_id_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  timeout_reg, timeout_next;

  logic [SRC_W-1:0]      pick_idx;
  logic                  pick_valid;

  fec_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req         (req_in),
    .last_grant  (last_grant_reg),
    .grant       (pick_idx),
    .grant_valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= SRC_W'(N_REQ - 1);
      enc_data_reg   <= '0;
      data_out_reg   <= '0;
      src_id_reg     <= '0;
      cnt_reg        <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      enc_data_reg   <= enc_data_next;
      data_out_reg   <= data_out_next;
      src_id_reg     <= src_id_next;
      cnt_reg        <= cnt_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    enc_data_next   = enc_data_reg;
    data_out_next   = data_out_reg;
    src_id_next     = src_id_reg;
    cnt_next        = cnt_reg;
    timeout_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en && pick_valid) begin
          grant_next    = pick_idx;
          enc_data_next = data_in[pick_idx];
          cnt_next      = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        // A completing ack takes precedence over an expiring watchdog.
        if (enc_ack) begin
          data_out_next = enc_result;
          src_id_next   = grant_reg;
          state_next    = RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_next    = 1'b1;
          last_grant_next = grant_reg;
          cnt_next        = '0;
          state_next      = IDLE;
        end
      end
      RESP: begin
        last_grant_next = grant_reg;
        cnt_next        = '0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
      assign ack_out[gi] = (state_reg == RESP) && (grant_reg == SRC_W'(gi));
    end
  endgenerate

  assign enc_req     = (state_reg == WAIT);
  assign busy        = (state_reg != IDLE);
  assign enc_data    = enc_data_reg;
  assign data_out    = data_out_reg;
  assign src_id      = src_id_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_fec_encoder_arbiter.sv
// Randomised scoreboard bench: expected grants come from a round-robin model,
// and a separate monitor checks each ack or timeout as it appears.
module tb_fec_encoder_arbiter;
  import encoder_fec_pkg::*;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int SW = $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic [N-1:0]          req_in = '0;
  message_data_t         data_in [N];
  logic [N-1:0]          ack_out;
  encoded_message_data_t data_out;
  logic [SW-1:0]         src_id;
  logic                  enc_req;
  message_data_t         enc_data;
  logic                  enc_ack = 1'b0;
  encoded_message_data_t enc_result = '0;
  logic                  busy;
  logic                  timeout_err;

  fec_encoder_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .en(en), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_out), .data_out(data_out), .src_id(src_id),
    .enc_req(enc_req), .enc_data(enc_data), .enc_ack(enc_ack),
    .enc_result(enc_result), .busy(busy), .timeout_err(timeout_err)
  );

  always #HALF_CLK_PERIOD clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                    hang;
    int                    g;
    encoded_message_data_t res;
    int                    due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ev_count = 0;
  int   lg_model = N - 1;
  bit   mon_on = 0;
  int   flush_cnt = 0;
  encoded_message_data_t last_data = '0;
  logic [SW-1:0]         last_src = '0;

  // encoder behaviour and stimulus knobs
  int lat = 1, lat_cur = 1, enc_k = 0;
  bit hang = 0, hang_cur = 0, spur = 0, gen = 0;
  int keep_mode = 0;

  // snapshot of the cycle about to be closed by the next edge
  bit            rst_q, idle_q, en_q, enc_req_q;
  logic [N-1:0]  req_q;
  message_data_t data_q [N];

  function automatic encoded_message_data_t enc_model(input message_data_t m);
    return {m, m ^ {m[3:0], m[7:4]}};
  endfunction

  function automatic int model_pick(input logic [N-1:0] r, input int lg);
    for (int k = 1; k <= N; k++) if (r[(lg + k) % N]) return (lg + k) % N;
    return -1;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ack_out"}, 32'(ack_out), 0);
    check_eq({tag, "_data_out"}, 32'(data_out), 0);
    check_eq({tag, "_src_id"}, 32'(src_id), 0);
    check_eq({tag, "_enc_req"}, 32'(enc_req), 0);
    check_eq({tag, "_enc_data"}, 32'(enc_data), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  // One clock: snapshot, advance, predict grants, drive encoder and requesters.
  task automatic step();
    rst_q = rst; en_q = en; req_q = req_in; data_q = data_in;
    idle_q = !enc_req && (ack_out == '0); enc_req_q = enc_req;
    @(posedge clk); #2;
    if (rst_q) begin
      enc_ack = 1'b0;
      enc_k   = 0;
    end else begin
      if (enc_req && !enc_req_q) begin
        int g;
        g = model_pick(req_q, lg_model);
        check_eq("grant_allowed", 32'(idle_q && en_q && g >= 0), 1);
        if (g < 0) g = 0;
        check_eq("grant_enc_data", 32'(enc_data), 32'(data_q[g]));
        hang_cur = hang;
        lat_cur  = lat;
        enc_k    = 0;
        sb.push_back('{hang_cur, g, enc_model(data_q[g]), hang_cur ? cyc + T : cyc + lat_cur + 1});
      end else if (enc_req) begin
        enc_k++;
      end
      if (idle_q && en_q && req_q != '0) check_eq("grant_taken", 32'(enc_req), 1);
      if (enc_req) begin
        enc_ack    = !hang_cur && (enc_k == lat_cur);
        enc_result = enc_ack ? enc_model(enc_data) : encoded_message_data_t'($urandom);
      end else begin
        enc_ack    = spur && ($urandom_range(0, 3) == 0);
        enc_result = encoded_message_data_t'($urandom);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ack_out[i]) begin
        if (keep_mode == 1 || (keep_mode == 2 && $urandom_range(0, 1) == 1))
          data_in[i] = message_data_t'($urandom);
        else
          req_in[i] = 1'b0;
      end else if (!req_in[i] && gen && $urandom_range(0, 2) == 0) begin
        req_in[i]  = 1'b1;
        data_in[i] = message_data_t'($urandom);
      end
    end
  endtask

  task automatic wait_events(input int n, input int budget);
    int target, k;
    target = ev_count + n;
    k = 0;
    while (ev_count < target && k < budget) begin
      step();
      k++;
    end
    if (ev_count < target) check_eq("event_wait_expired", 32'(ev_count), 32'(target));
  endtask

  task automatic wait_enc_req(input int budget);
    int k;
    k = 0;
    while (!enc_req && k < budget) begin
      step();
      k++;
    end
    check_eq("enc_req_wait", 32'(enc_req), 1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    gen = 0;
    keep_mode = 0;
    hang = 0;
    en = 1'b1;
    while ((req_in != '0 || busy || sb.size() != 0) && k < budget) begin
      step();
      k++;
    end
    check_eq("drain_idle", 32'(req_in != '0 || busy || sb.size() != 0), 0);
  endtask

  // Monitor: compare each ack or timeout with the oldest outstanding grant.
  initial begin
    exp_t e;
    int   flush_seen;
    flush_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        sb.delete();
        lg_model  = N - 1;
        last_data = '0;
        last_src  = '0;
      end
      if (mon_on) begin
        check_eq("busy", 32'(busy), 32'(enc_req || ack_out != '0));
        if (ack_out != '0 || timeout_err) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_event", 32'({ack_out, timeout_err}), 0);
          end else begin
            e = sb.pop_front();
            check_eq("event_cycle", 32'(cyc), 32'(e.due));
            if (e.hang) begin
              check_eq("timeout_err", 32'(timeout_err), 1);
              check_eq("ack_on_timeout", 32'(ack_out), 0);
              $display("txn %0d: ch %0d aborted by watchdog at cycle %0d", ev_count, e.g, cyc);
            end else begin
              check_eq("ack_out", 32'(ack_out), 32'(1) << e.g);
              check_eq("timeout_on_ack", 32'(timeout_err), 0);
              check_eq("src_id", 32'(src_id), 32'(e.g));
              check_eq("data_out", 32'(data_out), 32'(e.res));
              last_data = e.res;
              last_src  = SW'(e.g);
              $display("txn %0d: ch %0d acked data_out=%h at cycle %0d", ev_count, e.g, data_out, cyc);
            end
            lg_model = e.g;
            ev_count++;
          end
        end
        if (ack_out == '0) begin
          check_eq("data_out_hold", 32'(data_out), 32'(last_data));
          check_eq("src_id_hold", 32'(src_id), 32'(last_src));
        end
        if (sb.size() > 0 && cyc > sb[0].due) begin
          check_eq("event_missing", 32'(cyc), 32'(sb[0].due));
          lg_model = sb[0].g;
          void'(sb.pop_front());
          ev_count++;
        end
      end
    end
  end

  initial begin
    int cnt;
    for (int i = 0; i < N; i++) data_in[i] = '0;
    rst = 1'b1;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    mon_on = 1;

    // single channel, latency 3
    lat = 3; en = 1'b1; data_in[0] = 8'hA5; req_in = 4'b0001;
    wait_events(1, 40);
    drain(50);

    // all channels continuously, latency 1: strict rotation
    lat = 1; keep_mode = 1;
    for (int i = 0; i < N; i++) data_in[i] = message_data_t'($urandom);
    req_in = '1;
    wait_events(12, 200);
    drain(100);

    // channel 2, then 0 and 2 together: wrap serves 0 first
    data_in[2] = 8'h3C; req_in = 4'b0100;
    wait_events(1, 40);
    data_in[0] = 8'h81; data_in[2] = 8'h7E; req_in = 4'b0101;
    wait_events(2, 60);
    drain(50);

    // hung encoder: each requesting channel times out in turn, then recovers
    hang = 1; req_in = 4'b0011; data_in[0] = 8'h11; data_in[1] = 8'h22;
    wait_events(2, 60);
    hang = 0;
    wait_events(2, 60);
    drain(50);

    // reset in the middle of a long encode
    lat = 10; data_in[3] = 8'hC3; req_in = 4'b1000;
    wait_enc_req(20);
    step(); step(); step();
    mon_on = 0;
    rst = 1'b1;
    step();
    check_zero("rst_mid");
    rst = 1'b0;
    flush_cnt++;
    lat = 2; data_in[0] = 8'h5A; req_in = 4'b1001;
    mon_on = 1;
    wait_events(2, 60);
    drain(50);

    // en low blocks grants; en dropped in WAIT lets the transaction finish
    en = 1'b0; lat = 2;
    for (int i = 0; i < N; i++) data_in[i] = message_data_t'($urandom);
    req_in = '1;
    cnt = 0;
    repeat (20) begin
      step();
      if (enc_req) cnt++;
    end
    check_eq("en_low_no_grant", 32'(cnt), 0);
    en = 1'b1;
    wait_enc_req(5);
    en = 1'b0;
    wait_events(1, 30);
    cnt = 0;
    repeat (10) begin
      step();
      if (enc_req) cnt++;
    end
    check_eq("en_dropped_no_new_grant", 32'(cnt), 0);
    drain(100);

    // random traffic with spurious acks, random latency, hangs and en toggling
    spur = 1; gen = 1; keep_mode = 2;
    repeat (400) begin
      lat  = $urandom_range(1, 6);
      hang = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 7) != 0);
      step();
    end
    drain(400);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
